// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deframer.
// UART_RX_PARITY_EN adds an even-parity state after the data bits.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_e;

  function automatic logic even_par(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous serial line.
// Flops reset to 1 so the line reads idle out of reset.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with valid/ready output, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST =
    IW'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  uart_rx_state_e state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic rx_s;
  logic rx_d;
  logic frame_ok;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_i),
    .q  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign frame_ok = !par_bad;
`else
  assign frame_ok = 1'b1;
`endif

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rx_d        <= 1'b1;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      rx_d        <= rx_s;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= HALF;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt   <= FULL;
            idx   <= '0;
            state <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[idx] <= rx_s;
            cnt        <= FULL;
            if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad     <= even_par(shreg) != rx_s;
            frame_err_o <= even_par(shreg) != rx_s;
            cnt         <= FULL;
            state       <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            frame_err_o <= 1'b1;
            state       <= ST_WAIT_IDLE;
          end else begin
            state <= ST_IDLE;
            // a full holding register keeps the old byte
            if (frame_ok) begin
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed and random frames checked against a byte-queue model.
// Build with UART_RX_PARITY_EN to exercise 8E1 frames.
module tb_uart_rx_deframer;

  localparam int CPB = 32;
  localparam int SYN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int   vcyc = 0;
  int   fe_n = 0;
  int   ov_n = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) vcyc++;
      if (valid_o && ready_i) got.push_back(data_o);
      if (frame_err_o) fe_n++;
      if (overrun_o) ov_n++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    cyc(CPB);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    cyc(n);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input logic par_good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_good ? ^b : ~^b);
`else
    if (!par_good) $display("note: parity ignored");
`endif
    drive_bit(stop);
  endtask

  initial begin
    int v0;
    int f0;
    int o0;
    int nbad;
    logic [7:0] b;
    logic stop;
    logic pg;
    int kind;
    int gap;

    cyc(3);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_ferr", 32'(frame_err_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
    cyc(4);

    // single byte, ready high
    got.delete();
    v0 = vcyc; f0 = fe_n; o0 = ov_n;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(8);
    check("a5_vcyc", 32'(vcyc - v0), 1);
    check("a5_cnt", 32'(got.size()), 1);
    if (got.size() > 0) check("a5_data", 32'(got[0]), 32'hA5);
    check("a5_flags", 32'(fe_n - f0 + ov_n - o0), 0);

    // short low glitch, also start-entry latency
    v0 = vcyc; f0 = fe_n;
    rx_i = 1'b0;
    cyc(SYN);
    check("lat_busy_lo", 32'(busy_o), 0);
    cyc(1);
    check("lat_busy_hi", 32'(busy_o), 1);
    cyc(12 - SYN - 1);
    rx_i = 1'b1;
    cyc(24 - 12);
    check("gl_busy", 32'(busy_o), 0);
    idle(CPB * 12);
    check("gl_valid", 32'(vcyc - v0), 0);
    check("gl_ferr", 32'(fe_n - f0), 0);

    // stop bit low followed by a break
    got.delete();
    f0 = fe_n;
    send_frame(8'h3C, 1'b0, 1'b1);
    rx_i = 1'b0;
    cyc(100);
    check("brk_busy", 32'(busy_o), 1);
    check("brk_ferr", 32'(fe_n - f0), 1);
    check("brk_nodlv", 32'(got.size()), 0);
    idle(10);
    check("brk_idle", 32'(busy_o), 0);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(8);
    check("brk_cnt", 32'(got.size()), 1);
    if (got.size() > 0) check("brk_42", 32'(got[0]), 32'h42);

    // overrun with the consumer stalled
    got.delete();
    ready_i = 1'b0;
    o0 = ov_n;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(8);
    check("ovr_pulse", 32'(ov_n - o0), 1);
    check("ovr_hold", 32'(data_o), 32'h11);
    check("ovr_valid", 32'(valid_o), 1);
    ready_i = 1'b1;
    cyc(4);
    check("ovr_cnt", 32'(got.size()), 1);
    if (got.size() > 0) check("ovr_11", 32'(got[0]), 32'h11);
    check("ovr_clr", 32'(valid_o), 0);

    // back-to-back incrementing frames
    got.delete();
    for (int i = 0; i < 64; i++)
      send_frame(8'(i), 1'b1, 1'b1);
    idle(8);
    check("b2b_cnt", 32'(got.size()), 64);
    for (int i = 0; i < got.size(); i++)
      check("b2b_data", 32'(got[i]), 32'(i));

    // reset in the middle of bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_i = 1'b1;
    cyc(CPB / 2);
    rst = 1'b1;
    #1;
    check("mid_data", 32'(data_o), 32'h00);
    check("mid_valid", 32'(valid_o), 0);
    check("mid_busy", 32'(busy_o), 0);
    check("mid_flags",
          32'({frame_err_o, overrun_o}), 0);
    cyc(2);
    rst = 1'b0;
    idle(CPB * 6);
    got.delete();
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(8);
    check("mid_cnt", 32'(got.size()), 1);
    if (got.size() > 0) check("mid_5a", 32'(got[0]), 32'h5A);

`ifdef UART_RX_PARITY_EN
    got.delete();
    f0 = fe_n;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    check("par_ferr", 32'(fe_n - f0), 1);
    check("par_nodlv", 32'(got.size()), 0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_cnt", 32'(got.size()), 1);
    if (got.size() > 0) check("par_07", 32'(got[0]), 32'h07);
`endif

    // random frames, occasional framing errors
    got.delete();
    expq.delete();
    f0 = fe_n;
    nbad = 0;
    for (int i = 0; i < 30; i++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      stop = (kind != 0);
      pg   = 1'b1;
`ifdef UART_RX_PARITY_EN
      pg   = (kind != 1);
`endif
      send_frame(b, stop, pg);
      if (stop && pg) expq.push_back(b);
      else nbad++;
      gap = int'($urandom_range(0, 20));
      if (!stop) gap += 8;
      idle(gap);
    end
    idle(8);
    check("rnd_ferr", 32'(fe_n - f0), 32'(nbad));
    check("rnd_cnt", 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size(); i++)
      if (i < expq.size())
        check("rnd_data", 32'(got[i]), 32'(expq[i]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
